intersection_phase_scheduler: RTL

// - Sequences a two-road intersection (NS main road, EW side road) plus a pedestrian crossing.
// - Drives two one-hot RED/GREEN/YELLOW light groups and a WALK lamp.
// - NS holds green by default. EW green and the walk phase are granted only on latched requests.
// - An all-red clearance interval always separates conflicting greens.

---
 rtl/intersection_phase_scheduler_pkg.sv | 26 ++
 rtl/intersection_phase_scheduler_timer.sv | 37 +++
 rtl/intersection_phase_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/intersection_phase_scheduler_pkg.sv
// intersection_phase_scheduler_pkg
// Shared definitions for the intersection phase scheduler:
//   - phase_e : 3-bit state codes, also visible on the state_o debug port
//   - dir_e   : which road gets the next green after an all-red interval
//   - LT_*    : one-hot light codes, ordered {RED,GREEN,YELLOW}
package intersection_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED    = 3'd0,
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_EW_GREEN  = 3'd3,
    ST_EW_YELLOW = 3'd4,
    ST_PED_WALK  = 3'd5
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam logic [2:0] LT_RED    = 3'b100;
  localparam logic [2:0] LT_GREEN  = 3'b010;
  localparam logic [2:0] LT_YELLOW = 3'b001;

endpackage

// File: rtl/intersection_phase_scheduler_timer.sv
// intersection_phase_scheduler_timer
// Phase down-counter. Loads a new duration when the scheduler changes
// state, otherwise counts down one per clock and saturates at zero.
// Ports:
//   clk      in   rising-edge clock
//   rs       in   synchronous active-high reset, loads RST_VAL
//   load     in   load load_val on this edge (takes priority over counting)
//   load_val in   duration to load, TW bits
//   zero     out  counter is at zero (current phase expires this cycle)
module intersection_phase_scheduler_timer #(
  parameter int             TW      = 8,
  parameter logic [TW-1:0]  RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rs,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] t;

  // Saturating count: once at zero the value holds until the next load,
  // which lets the NS green phase sit indefinitely with t == 0.
  always_ff @(posedge clk) begin
    if (rs) begin
      t <= RST_VAL;
    end else if (load) begin
      t <= load_val;
    end else if (t != '0) begin
      t <= t - TW'(1);
    end
  end

  assign zero = (t == '0);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// intersection_phase_scheduler
// Sequences a two-road intersection (NS main road, EW side road) plus a
// pedestrian crossing. NS rests in green; EW green and the walk phase are
// only granted on latched requests, always separated by all-red clearance.
// Ports:
//   clk       in   rising-edge clock
//   rs        in   synchronous active-high reset
//   car_ew    in   EW vehicle detector (level or pulse)
//   ped_req   in   pedestrian push-button (level or pulse)
//   ns_light  out  NS lights {RED,GREEN,YELLOW}, one-hot
//   ew_light  out  EW lights {RED,GREEN,YELLOW}, one-hot
//   walk      out  pedestrian WALK lamp
//   state_o   out  current state code (phase_e)
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int TW         = 8,
  parameter int T_GREEN_NS = 20,
  parameter int T_GREEN_EW = 15,
  parameter int T_YELLOW   = 5,
  parameter int T_ALLRED   = 2,
  parameter int T_WALK     = 10
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk,
  output logic [2:0] state_o
);

  phase_e        state, state_nxt;
  dir_e          nxt_dir, nxt_dir_nxt;
  logic          car_pend, car_pend_nxt;
  logic          ped_pend, ped_pend_nxt;
  logic          t_zero;
  logic          load;
  logic [TW-1:0] load_val;
  logic          enter_ew, enter_walk;

  intersection_phase_scheduler_timer #(
    .TW      (TW),
    .RST_VAL (TW'(T_ALLRED))
  ) u_timer (
    .clk      (clk),
    .rs       (rs),
    .load     (load),
    .load_val (load_val),
    .zero     (t_zero)
  );

  always_ff @(posedge clk) begin
    if (rs) begin
      state    <= ST_ALLRED;
      nxt_dir  <= DIR_NS;
      car_pend <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      nxt_dir  <= nxt_dir_nxt;
      car_pend <= car_pend_nxt;
      ped_pend <= ped_pend_nxt;
    end
  end

  // Transitions only happen when the phase timer has run out. NS green is
  // the resting phase: it waits at t == 0 until some request is latched.
  // Unused state codes fall back to a fresh all-red clearance toward NS.
  always_comb begin
    state_nxt   = state;
    nxt_dir_nxt = nxt_dir;
    case (state)
      ST_ALLRED: begin
        if (t_zero) begin
          if (ped_pend)              state_nxt = ST_PED_WALK;
          else if (nxt_dir == DIR_NS) state_nxt = ST_NS_GREEN;
          else                        state_nxt = ST_EW_GREEN;
        end
      end
      ST_PED_WALK: begin
        if (t_zero) state_nxt = (nxt_dir == DIR_NS) ? ST_NS_GREEN : ST_EW_GREEN;
      end
      ST_NS_GREEN: begin
        if (t_zero && (car_pend || ped_pend)) state_nxt = ST_NS_YELLOW;
      end
      ST_NS_YELLOW: begin
        if (t_zero) begin
          state_nxt   = ST_ALLRED;
          nxt_dir_nxt = car_pend ? DIR_EW : DIR_NS;
        end
      end
      ST_EW_GREEN: begin
        if (t_zero) state_nxt = ST_EW_YELLOW;
      end
      ST_EW_YELLOW: begin
        if (t_zero) begin
          state_nxt   = ST_ALLRED;
          nxt_dir_nxt = DIR_NS;
        end
      end
      default: begin
        state_nxt   = ST_ALLRED;
        nxt_dir_nxt = DIR_NS;
      end
    endcase
  end

  // The timer is reloaded with the duration of whichever state is being
  // entered; a state that persists keeps counting (or sits at zero).
  always_comb begin
    load     = (state_nxt != state);
    load_val = TW'(T_ALLRED);
    case (state_nxt)
      ST_NS_GREEN:  load_val = TW'(T_GREEN_NS);
      ST_NS_YELLOW: load_val = TW'(T_YELLOW);
      ST_EW_GREEN:  load_val = TW'(T_GREEN_EW);
      ST_EW_YELLOW: load_val = TW'(T_YELLOW);
      ST_PED_WALK:  load_val = TW'(T_WALK);
      default:      load_val = TW'(T_ALLRED);
    endcase
  end

  // Request latches. The clear on entering the served phase beats a
  // request arriving on the same edge, and button presses during the walk
  // itself are not remembered.
  always_comb begin
    enter_ew     = (state_nxt == ST_EW_GREEN) && (state != ST_EW_GREEN);
    enter_walk   = (state_nxt == ST_PED_WALK) && (state != ST_PED_WALK);
    car_pend_nxt = enter_ew ? 1'b0 : (car_pend | car_ew);
    if (enter_walk)                ped_pend_nxt = 1'b0;
    else if (state == ST_PED_WALK) ped_pend_nxt = ped_pend;
    else                           ped_pend_nxt = ped_pend | ped_req;
  end

  // Lights decode from the registered state only; anything unexpected
  // shows red on both roads.
  always_comb begin
    ns_light = LT_RED;
    ew_light = LT_RED;
    walk     = 1'b0;
    case (state)
      ST_NS_GREEN:  ns_light = LT_GREEN;
      ST_NS_YELLOW: ns_light = LT_YELLOW;
      ST_EW_GREEN:  ew_light = LT_GREEN;
      ST_EW_YELLOW: ew_light = LT_YELLOW;
      ST_PED_WALK:  walk     = 1'b1;
      default: begin
        ns_light = LT_RED;
        ew_light = LT_RED;
      end
    endcase
  end

  assign state_o = state;

endmodule
